// File: rtl/axi4_sram_slave_burst.sv
// AXI4 memory target over a 1W1R word SRAM: INCR/WRAP/FIXED bursts, byte strobes, SLVERR on bad beats.
// Read data is registered (beat 0 one cycle after AR); write response follows the last W beat.
module axi4_sram_slave_burst #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int ID_W   = 8,
  parameter int LEN_W  = 8,
  parameter int DEPTH  = 16384
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic [ID_W-1:0]   AWID,
  input  logic [ADDR_W-1:0] AWADDR,
  input  logic [LEN_W-1:0]  AWLEN,
  input  logic [2:0]        AWSIZE,
  input  logic [1:0]        AWBURST,
  input  logic              AWVALID,
  output logic              AWREADY,
  input  logic [DATA_W-1:0] WDATA,
  input  logic [DATA_W/8-1:0] WSTRB,
  input  logic              WLAST,
  input  logic              WVALID,
  output logic              WREADY,
  output logic [ID_W-1:0]   BID,
  output logic [1:0]        BRESP,
  output logic              BVALID,
  input  logic              BREADY,
  input  logic [ID_W-1:0]   ARID,
  input  logic [ADDR_W-1:0] ARADDR,
  input  logic [LEN_W-1:0]  ARLEN,
  input  logic [2:0]        ARSIZE,
  input  logic [1:0]        ARBURST,
  input  logic              ARVALID,
  output logic              ARREADY,
  output logic [ID_W-1:0]   RID,
  output logic [DATA_W-1:0] RDATA,
  output logic [1:0]        RRESP,
  output logic              RLAST,
  output logic              RVALID,
  input  logic              RREADY
);
  localparam int STRB_W = DATA_W / 8;
  localparam int OFF_W  = $clog2(STRB_W);
  localparam int IDX_W  = $clog2(DEPTH);

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_DATA = 2'd1;
  localparam logic [1:0] W_RESP = 2'd2;
  localparam logic [0:0] R_IDLE = 1'b0;
  localparam logic [0:0] R_DATA = 1'b1;
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [LEN_W-1:0] ONE_L = LEN_W'(1);

  logic [DATA_W-1:0] mem [DEPTH];

  function automatic logic bad_req(input logic [2:0] sz, input logic [LEN_W-1:0] ln, input logic [1:0] bt);
    logic wrap_len_ok;
    wrap_len_ok = (ln == LEN_W'(1)) || (ln == LEN_W'(3)) || (ln == LEN_W'(7)) || (ln == LEN_W'(15));
    return (sz > 3'(OFF_W)) || (bt == 2'b11) || ((bt == 2'b10) && !wrap_len_ok);
  endfunction

  function automatic logic oor(input logic [ADDR_W-1:0] a);
    return (a >> OFF_W) >= ADDR_W'(DEPTH);
  endfunction

  function automatic logic [IDX_W-1:0] idx(input logic [ADDR_W-1:0] a);
    return IDX_W'(a >> OFF_W);
  endfunction

  // WRAP base is recovered from the current address since every beat stays inside the window.
  function automatic logic [ADDR_W-1:0] addr_next(input logic [ADDR_W-1:0] a, input logic [2:0] sz,
                                                  input logic [LEN_W-1:0] ln, input logic [1:0] bt);
    logic [ADDR_W-1:0] step, win;
    step = ADDR_W'(1) << sz;
    win  = (ADDR_W'(ln) + ADDR_W'(1)) << sz;
    case (bt)
      2'b00:   return a;
      2'b10:   return (a & ~(win - ADDR_W'(1))) | ((a + step) & (win - ADDR_W'(1)));
      default: return a + step;
    endcase
  endfunction

  // Handshake readies stay low until the first clock after reset release.
  logic live;
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) live <= 1'b0;
    else        live <= 1'b1;
  end

  logic [1:0]        w_state;
  logic [ID_W-1:0]   w_id;
  logic [ADDR_W-1:0] w_addr;
  logic [LEN_W-1:0]  w_len, w_cnt;
  logic [2:0]        w_size;
  logic [1:0]        w_burst;
  logic              w_berr, w_err;
  logic              w_fire, w_last_beat, w_beat_err;

  assign AWREADY     = live && (w_state == W_IDLE);
  assign WREADY      = (w_state == W_DATA);
  assign BVALID      = (w_state == W_RESP);
  assign BID         = w_id;
  assign BRESP       = (BVALID && w_err) ? SLVERR : OKAY;
  assign w_fire      = WVALID && WREADY;
  assign w_last_beat = (w_cnt == w_len);
  assign w_beat_err  = w_berr || oor(w_addr) || (WLAST != w_last_beat);

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      w_state <= W_IDLE;
      w_id    <= '0;
      w_addr  <= '0;
      w_len   <= '0;
      w_cnt   <= '0;
      w_size  <= '0;
      w_burst <= '0;
      w_berr  <= 1'b0;
      w_err   <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: if (AWVALID && AWREADY) begin
          w_id    <= AWID;
          w_addr  <= AWADDR;
          w_len   <= AWLEN;
          w_size  <= AWSIZE;
          w_burst <= AWBURST;
          w_berr  <= bad_req(AWSIZE, AWLEN, AWBURST);
          w_err   <= 1'b0;
          w_cnt   <= '0;
          w_state <= W_DATA;
        end
        W_DATA: if (w_fire) begin
          w_err  <= w_err | w_beat_err;
          w_addr <= addr_next(w_addr, w_size, w_len, w_burst);
          if (w_last_beat) w_state <= W_RESP;
          else             w_cnt   <= w_cnt + ONE_L;
        end
        W_RESP: if (BREADY) w_state <= W_IDLE;
        default: w_state <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge ACLK) begin
    if (w_fire && !w_beat_err) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (WSTRB[b]) mem[idx(w_addr)][8*b +: 8] <= WDATA[8*b +: 8];
      end
    end
  end

  logic [0:0]        r_state;
  logic [ID_W-1:0]   r_id;
  logic [ADDR_W-1:0] r_addr, r_nxt_addr, f_addr;
  logic [LEN_W-1:0]  r_len, r_cnt;
  logic [2:0]        r_size;
  logic [1:0]        r_burst;
  logic              r_berr, f_err, ar_fire, r_fire;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;

  assign ARREADY    = live && (r_state == R_IDLE);
  assign RVALID     = (r_state == R_DATA);
  assign RID        = r_id;
  assign RDATA      = rdata;
  assign RRESP      = rresp;
  assign RLAST      = rlast;
  assign ar_fire    = ARVALID && ARREADY;
  assign r_fire     = RVALID && RREADY;
  assign r_nxt_addr = addr_next(r_addr, r_size, r_len, r_burst);
  assign f_addr     = ar_fire ? ARADDR : r_nxt_addr;
  assign f_err      = ar_fire ? (bad_req(ARSIZE, ARLEN, ARBURST) || oor(ARADDR))
                              : (r_berr || oor(r_nxt_addr));

  // The fetch samples the array at the same edge a write commits, so it sees pre-write data.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_state <= R_IDLE;
      r_id    <= '0;
      r_addr  <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
      r_size  <= '0;
      r_burst <= '0;
      r_berr  <= 1'b0;
      rdata   <= '0;
      rresp   <= OKAY;
      rlast   <= 1'b0;
    end else begin
      if (ar_fire || (r_fire && !rlast)) begin
        rdata <= f_err ? '0 : mem[idx(f_addr)];
        rresp <= f_err ? SLVERR : OKAY;
      end
      case (r_state)
        R_IDLE: if (ar_fire) begin
          r_id    <= ARID;
          r_addr  <= ARADDR;
          r_len   <= ARLEN;
          r_size  <= ARSIZE;
          r_burst <= ARBURST;
          r_berr  <= bad_req(ARSIZE, ARLEN, ARBURST);
          r_cnt   <= '0;
          rlast   <= (ARLEN == '0);
          r_state <= R_DATA;
        end
        R_DATA: if (r_fire) begin
          if (rlast) begin
            rlast   <= 1'b0;
            r_state <= R_IDLE;
          end else begin
            r_addr <= r_nxt_addr;
            r_cnt  <= r_cnt + ONE_L;
            rlast  <= ((r_cnt + ONE_L) == r_len);
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end
endmodule
